// File: rtl/miner_pkg.sv
// Shared types and constants for the miner result path.
// Used by both the host-facing receive and transmit blocks.
package miner_pkg;

  localparam int RESULT_BITS = 288;
  localparam int RESULT_BYTES = RESULT_BITS / 8;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    PAYLOAD,
    CSUM
  } tx_state_t;

endpackage

// File: rtl/result_tx_framer.sv
// Frames a captured result word as sync + payload + XOR checksum
// bytes over a valid/ready byte stream toward the host link.
module result_tx_framer
  import miner_pkg::*;
#(
  parameter int DATA_BITS = RESULT_BITS,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 send_data,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 byte_ready,
  output logic                 byte_valid,
  output logic [7:0]           byte_out,
  output logic                 busy,
  output logic                 dropped
);

  localparam int NBYTES = DATA_BITS / 8;
  localparam logic [5:0] LAST = 6'(NBYTES - 1);

  tx_state_t state, state_d;
  logic [DATA_BITS-1:0] sreg, sreg_d;
  logic [5:0] cnt, cnt_d;
  logic [7:0] csum, csum_d;
  logic [7:0] byte_d;
  logic xfer;

  assign xfer = byte_valid && byte_ready;

  always_comb begin
    state_d = state;
    sreg_d  = sreg;
    cnt_d   = cnt;
    csum_d  = csum;
    unique case (state)
      IDLE: begin
        if (send_data) begin
          sreg_d  = tx_data;
          csum_d  = 8'h00;
          cnt_d   = 6'd0;
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (xfer) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        if (xfer) begin
          csum_d = csum ^ sreg[DATA_BITS-1 -: 8];
          sreg_d = {sreg[DATA_BITS-9:0], 8'h00};
          cnt_d  = cnt + 6'd1;
          if (cnt == LAST) state_d = CSUM;
        end
      end
      CSUM: begin
        if (xfer) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so they are computed from next-state values.
  always_comb begin
    byte_d = 8'h00;
    unique case (state_d)
      IDLE:    byte_d = 8'h00;
      SYNC:    byte_d = SYNC_BYTE;
      PAYLOAD: byte_d = sreg_d[DATA_BITS-1 -: 8];
      CSUM:    byte_d = csum_d;
      default: byte_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= 6'd0;
      csum       <= 8'h00;
      byte_valid <= 1'b0;
      byte_out   <= 8'h00;
      busy       <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      state      <= state_d;
      sreg       <= sreg_d;
      cnt        <= cnt_d;
      csum       <= csum_d;
      byte_valid <= (state_d != IDLE);
      byte_out   <= byte_d;
      busy       <= (state_d != IDLE);
      dropped    <= send_data && (state != IDLE);
    end
  end

endmodule
